// File: rtl/du_ram_loader.sv
// DU RAM writer: takes 8x8 blocks of YUV 4:4:4 pixels and writes the Y, U and V planes
// into a 192-byte RAM, then holds the block for the encoder until it acknowledges.
module du_ram_loader (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_y,
    input  logic [7:0] pix_u,
    input  logic [7:0] pix_v,
    output logic [7:0] du_ram_aw,
    output logic [7:0] du_ram_di,
    output logic       du_ram_we,
    output logic       du_blk_valid,
    input  logic       du_blk_ack,
    output logic [7:0] blk_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WR_Y,
        S_WR_U,
        S_WR_V,
        S_FULL
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_idx;
    logic [7:0] r_py;
    logic [7:0] r_pu;
    logic [7:0] r_pv;
    logic [7:0] r_blk_count;
    logic       w_last;
    logic       w_take;
    logic [7:0] w_idx8;

    assign w_last    = (r_idx == 6'd63);
    assign w_idx8    = {2'b00, r_idx};
    assign w_take    = pix_valid && pix_ready;
    assign blk_count = r_blk_count;

    // Outputs depend only on r_state/r_idx/capture regs; inputs only steer w_next.
    always_comb begin
        w_next       = r_state;
        pix_ready    = 1'b0;
        du_ram_we    = 1'b0;
        du_ram_aw    = 8'd0;
        du_ram_di    = 8'd0;
        du_blk_valid = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_ACCEPT;
            S_ACCEPT: begin
                pix_ready = 1'b1;
                if (pix_valid) w_next = S_WR_Y;
            end
            S_WR_Y: begin
                du_ram_we = 1'b1;
                du_ram_aw = w_idx8;
                du_ram_di = r_py;
                w_next    = S_WR_U;
            end
            S_WR_U: begin
                du_ram_we = 1'b1;
                du_ram_aw = w_idx8 + 8'd64;
                du_ram_di = r_pu;
                w_next    = S_WR_V;
            end
            S_WR_V: begin
                du_ram_we = 1'b1;
                du_ram_aw = w_idx8 + 8'd128;
                du_ram_di = r_pv;
                if (w_last) begin
                    w_next = S_FULL;
                end else begin
                    // Overlap the next accept with the V write to sustain 1 pixel / 3 cycles.
                    pix_ready = 1'b1;
                    w_next    = pix_valid ? S_WR_Y : S_ACCEPT;
                end
            end
            S_FULL: begin
                du_blk_valid = 1'b1;
                if (du_blk_ack) w_next = S_ACCEPT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 6'd0;
            r_py        <= 8'd0;
            r_pu        <= 8'd0;
            r_pv        <= 8'd0;
            r_blk_count <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_py <= pix_y;
                r_pu <= pix_u;
                r_pv <= pix_v;
            end
            if (r_state == S_WR_V) r_idx <= w_last ? 6'd0 : r_idx + 6'd1;
            if (r_state == S_FULL && du_blk_ack) r_blk_count <= r_blk_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_du_ram_loader.sv
// Bench for du_ram_loader: queue-based write model checked every cycle, plus directed
// literal checks on reset, latency, block handoff, counter wrap and mid-block reset.
module tb_du_ram_loader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_y = 8'd0, pix_u = 8'd0, pix_v = 8'd0;
    logic       du_blk_ack = 1'b0;
    logic       pix_ready, du_ram_we, du_blk_valid;
    logic [7:0] du_ram_aw, du_ram_di, blk_count;

    du_ram_loader dut (
        .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_y(pix_y), .pix_u(pix_u), .pix_v(pix_v),
        .du_ram_aw(du_ram_aw), .du_ram_di(du_ram_di), .du_ram_we(du_ram_we),
        .du_blk_valid(du_blk_valid), .du_blk_ack(du_blk_ack), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: a queue of pending RAM writes, one popped per cycle.
    typedef struct packed {logic [7:0] aw; logic [7:0] di;} wr_t;
    typedef struct {int c; logic [7:0] aw; logic [7:0] di;} wl_t;
    wr_t        m_q[$];
    int         m_pix = 0;
    bit         m_full = 0, m_boot = 1, m_live = 0;
    logic [7:0] m_cnt = 8'd0;

    wl_t        wlog[$];
    int         acc_log[$];
    int         rise_cyc = -1;
    bit         prev_valid = 0;
    logic [7:0] ram [0:191];

    function automatic bit m_ready();
        return !m_boot && !m_full && m_q.size() <= 1 && m_pix < 64;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Inputs change only just after posedge, so values seen here are what the next edge samples.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            logic [31:0] e, a;
            bit  ew;
            ew = m_q.size() > 0;
            e  = {5'd0, m_ready(), ew, m_full, ew ? m_q[0].aw : 8'd0, ew ? m_q[0].di : 8'd0, m_cnt};
            a  = {5'd0, pix_ready, du_ram_we, du_blk_valid, du_ram_aw, du_ram_di, blk_count};
            chk("cycle outputs {rdy,we,bv,aw,di,cnt}", a, e);
        end
        if (du_ram_we === 1'b1) begin
            wlog.push_back('{cyc, du_ram_aw, du_ram_di});
            if (du_ram_aw < 8'd192) ram[du_ram_aw] = du_ram_di;
        end
        if (pix_valid && pix_ready === 1'b1) acc_log.push_back(cyc);
        if (du_blk_valid === 1'b1 && !prev_valid) rise_cyc = cyc;
        prev_valid = (du_blk_valid === 1'b1);
        if (!reset_n) begin
            m_q.delete();
            m_pix = 0; m_full = 0; m_boot = 1; m_cnt = 8'd0; m_live = 1;
        end else if (m_live) begin
            bit acc;
            acc = pix_valid && m_ready();
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (acc) begin
                wr_t w;
                w.aw = 8'(m_pix);        w.di = pix_y; m_q.push_back(w);
                w.aw = 8'(m_pix) + 8'd64;  w.di = pix_u; m_q.push_back(w);
                w.aw = 8'(m_pix) + 8'd128; w.di = pix_v; m_q.push_back(w);
                m_pix++;
            end
            if (m_full) begin
                if (du_blk_ack) begin m_full = 0; m_cnt++; m_pix = 0; end
            end else if (m_q.size() == 0 && m_pix == 64) begin
                m_full = 1;
            end
            m_boot = 0;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
        bit ok;
        ok = 0;
        pix_y = y; pix_u = u; pix_v = v; pix_valid = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (pix_ready === 1'b1) begin ok = 1; break; end
        end
        if (!ok) chk("accept timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic block(input bit gaps);
        for (int i = 0; i < 64; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                pix_valid = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
            end
            send(8'(i), 8'(8'h40 + i), 8'(8'h80 + i));
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_blk(output int c);
        bit ok;
        ok = 0; c = -1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (du_blk_valid === 1'b1) begin ok = 1; c = cyc; break; end
        end
        if (!ok) chk("blk_valid timeout", 0, 1);
    endtask

    task automatic fast_block();
        int c;
        block(0);
        wait_blk(c);
        tick();
        du_blk_ack = 1'b1; tick(); du_blk_ack = 1'b0;
    endtask

    function automatic int ram_errs();
        int e;
        e = 0;
        for (int i = 0; i < 64; i++) begin
            if (ram[i] !== 8'(i)) e++;
            if (ram[64 + i] !== 8'(8'h40 + i)) e++;
            if (ram[128 + i] !== 8'(8'h80 + i)) e++;
        end
        return e;
    endfunction

    initial begin
        int c, cf;
        for (int i = 0; i < 192; i++) ram[i] = 8'hEE;

        // Reset: 3 cycles low, then release
        repeat (3) tick();
        @(negedge clk);
        chk("reset outputs", {pix_ready, du_ram_we, du_blk_valid, du_ram_aw, du_ram_di, blk_count}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready before first high edge", pix_ready, 0);
        tick();
        @(negedge clk);
        chk("ready 1 cycle after release", pix_ready, 1);
        chk("blk_count after reset", blk_count, 0);
        tick();

        // Single pixel
        wlog.delete(); acc_log.delete();
        send(8'h11, 8'h22, 8'h33);
        pix_valid = 1'b0;
        c = acc_log[0];
        tick(); tick();
        @(negedge clk);
        chk("ready at c+3", pix_ready, 1);
        chk("single write count", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("Y write", {wlog[0].c - c, 8'(wlog[0].aw), 8'(wlog[0].di)}, {32'd1, 8'd0, 8'h11});
            chk("U write", {wlog[1].c - c, 8'(wlog[1].aw), 8'(wlog[1].di)}, {32'd2, 8'd64, 8'h22});
            chk("V write", {wlog[2].c - c, 8'(wlog[2].aw), 8'(wlog[2].di)}, {32'd3, 8'd128, 8'h33});
        end
        tick();
        reset_n = 1'b0; tick(); tick();
        reset_n = 1'b1; tick(); tick();

        // Full block back-to-back
        wlog.delete(); acc_log.delete(); rise_cyc = -1;
        block(0);
        wait_blk(cf);
        chk("b2b write count", wlog.size(), 192);
        chk("b2b last write", {wlog[$].aw, wlog[$].di}, {8'd191, 8'hBF});
        chk("b2b accept->blk_valid", cf - acc_log[0], 193);
        chk("ready low while full", pix_ready, 0);
        chk("b2b ram image errors", ram_errs(), 0);
        @(posedge clk); #1;
        repeat (4) tick();
        du_blk_ack = 1'b1; tick(); du_blk_ack = 1'b0;
        @(negedge clk);
        chk("blk_count after ack", blk_count, 1);
        chk("ready after ack", pix_ready, 1);
        tick();

        // Stalls plus stray acks in ACCEPT and final WR_V
        for (int i = 0; i < 192; i++) ram[i] = 8'hEE;
        wlog.delete();
        du_blk_ack = 1'b1; tick(); du_blk_ack = 1'b0;
        block(1);
        tick(); tick();
        du_blk_ack = 1'b1; tick(); du_blk_ack = 1'b0;
        @(negedge clk);
        chk("full after stray ack", du_blk_valid, 1);
        chk("blk_count after stray acks", blk_count, 1);
        repeat (3) tick();
        chk("stall write count", wlog.size(), 192);
        chk("stall ram image errors", ram_errs(), 0);
        du_blk_ack = 1'b1; tick(); du_blk_ack = 1'b0;
        @(negedge clk);
        chk("blk_count after real ack", blk_count, 2);
        tick();

        // Counter wrap: 256 blocks in total
        repeat (253) fast_block();
        @(negedge clk);
        chk("blk_count 255", blk_count, 255);
        tick();
        fast_block();
        @(negedge clk);
        chk("blk_count wrap", blk_count, 0);
        tick();

        // Reset just after the Y write of pixel 10 begins
        for (int i = 0; i < 10; i++) send(8'(i), 8'(8'h40 + i), 8'(8'h80 + i));
        send(8'd10, 8'h4A, 8'h8A);
        wlog.delete();
        pix_valid = 1'b0;
        reset_n = 1'b0;
        repeat (3) tick();
        chk("writes around reset", wlog.size(), 1);
        if (wlog.size() > 0) chk("in-flight Y write", {wlog[0].aw, wlog[0].di}, {8'd10, 8'd10});
        reset_n = 1'b1; tick();
        wlog.delete();
        send(8'h5A, 8'h6B, 8'h7C);
        pix_valid = 1'b0;
        repeat (3) tick();
        chk("restart write count", wlog.size(), 3);
        if (wlog.size() > 0) chk("restart first write", {wlog[0].aw, wlog[0].di}, {8'd0, 8'h5A});
        @(negedge clk);
        chk("blk_count after mid reset", blk_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
